// File: rtl/l15_req_port_arbiter_pkg.sv
// Shared adapter package: requester port indices and arbiter state encoding.
package l15_req_port_arbiter_pkg;

  localparam int unsigned NUM_L15_PORTS = 6;

  localparam int unsigned ICACHE    = 0;
  localparam int unsigned DCACHE    = 1;
  localparam int unsigned WBUF      = 2;
  localparam int unsigned UNC_READ  = 3;
  localparam int unsigned UNC_WRITE = 4;
  localparam int unsigned AMO       = 5;

  typedef logic [$clog2(NUM_L15_PORTS)-1:0] req_portid_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/l15_port_credit_ctr.sv
// Per-port bookkeeping: in-flight request count and wait-age counter.
module l15_port_credit_ctr #(
  parameter int unsigned StarveTh       = 15,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic accept,
  input  logic rtrn,
  output logic eligible,
  output logic starving,
  output logic busy,
  output logic rtrn_err
);

  localparam int unsigned AgeW = $clog2(StarveTh + 1);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

  logic [AgeW-1:0] age_q;
  logic [OutW-1:0] out_q;

  // Age counts cycles spent waiting; saturates so a starving port stays starving.
  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else if (!req_valid || accept) begin
      age_q <= '0;
    end else if (age_q != AgeW'(StarveTh)) begin
      age_q <= age_q + 1'b1;
    end
  end

  // Outstanding count; a simultaneous accept and return cancel out, and a
  // return with nothing in flight leaves the count at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (accept && !rtrn) begin
      out_q <= out_q + 1'b1;
    end else if (rtrn && !accept && (out_q != '0)) begin
      out_q <= out_q - 1'b1;
    end
  end

  assign eligible = req_valid && (out_q < OutW'(MaxOutstanding));
  assign starving = age_q >= AgeW'(StarveTh);
  assign busy     = out_q != '0;
  assign rtrn_err = rtrn && (out_q == '0);

endmodule

// File: rtl/l15_req_port_arbiter.sv
// Fixed-priority request arbiter toward the L1.5 channel with starvation
// override and per-port outstanding-request credit limits.
module l15_req_port_arbiter
  import l15_req_port_arbiter_pkg::*;
#(
  parameter int unsigned NumPorts       = 6,
  parameter int unsigned StarveTh       = 15,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumPorts-1:0]         req_valid_i,
  output logic [NumPorts-1:0]         req_ready_o,
  output logic                        grant_valid_o,
  output logic [$clog2(NumPorts)-1:0] grant_portid_o,
  input  logic                        grant_ready_i,
  input  logic                        rtrn_valid_i,
  input  logic [$clog2(NumPorts)-1:0] rtrn_portid_i,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned IdW = $clog2(NumPorts);

  arb_state_e          state_q, state_d;
  logic [IdW-1:0]      portid_q, portid_d;
  logic [IdW-1:0]      winner;
  logic [NumPorts-1:0] eligible, starving, pick, rtrn_hit, rtrn_err, pending;
  logic                bad_id;
  logic                err_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign rtrn_hit[p] = rtrn_valid_i && (rtrn_portid_i == IdW'(p));

    l15_port_credit_ctr #(
      .StarveTh       (StarveTh),
      .MaxOutstanding (MaxOutstanding)
    ) u_ctr (
      .clk       (clk_i),
      .rst       (rst_i),
      .req_valid (req_valid_i[p]),
      .accept    (req_ready_o[p]),
      .rtrn      (rtrn_hit[p]),
      .eligible  (eligible[p]),
      .starving  (starving[p]),
      .busy      (pending[p]),
      .rtrn_err  (rtrn_err[p])
    );
  end

  // Lowest-index starving eligible port wins; otherwise lowest-index eligible.
  // Scanning high-to-low lets the last hit (lowest index) stick.
  always_comb begin
    pick   = (|(eligible & starving)) ? (eligible & starving) : eligible;
    winner = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (pick[NumPorts-1-i]) winner = IdW'(NumPorts - 1 - i);
    end
  end

  // Next-state: register a winner from IDLE, release HOLD on the handshake.
  always_comb begin
    state_d  = state_q;
    portid_d = portid_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = HOLD;
          portid_d = winner;
        end
      end
      HOLD: begin
        if (grant_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and granted-port registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      portid_q <= '0;
    end else begin
      state_q  <= state_d;
      portid_q <= portid_d;
    end
  end

  // Accept pulse to the granted requester in the handshake cycle.
  always_comb begin
    req_ready_o = '0;
    if ((state_q == HOLD) && grant_ready_i) req_ready_o[portid_q] = 1'b1;
  end

  assign bad_id = rtrn_valid_i && ({1'b0, rtrn_portid_i} >= (IdW + 1)'(NumPorts));

  // Sticky error for orphan completions and out-of-range return ids.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if ((|rtrn_err) || bad_id) begin
      err_q <= 1'b1;
    end
  end

  assign grant_valid_o  = (state_q == HOLD);
  assign grant_portid_o = portid_q;
  assign busy_o         = grant_valid_o || (|pending);
  assign err_o          = err_q;

endmodule
